// File: rtl/counter_pkg.sv
// Shared definitions for the counter/sequencer library: direction encodings
// and the binary-to-Gray helper used by every counter variant.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Fixed 32-bit datapath; callers zero-extend and truncate to their width,
   // which yields the same code as a native-width encode.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_out_reg.sv
// Gray-encodes a binary count and registers it; one cycle behind its input.
import counter_pkg::*;

module gray_out_reg #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   logic [WIDTH-1:0] gray_d;
   logic [WIDTH-1:0] gray_q;

   always_comb begin
      gray_d = WIDTH'(bin2gray(32'(bin)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q <= '0;
      end else begin
         gray_q <= gray_d;
      end
   end

   assign gray = gray_q;

endmodule

// File: rtl/moore_updown_counter.sv
// Modulo-MODULUS up/down Moore counter with enable, range-checked load,
// terminal flags and wrap/load-error pulses. Define MOORE_COUNTER_GRAY_OUT_EN for Gray-coded out.
import counter_pkg::*;

module moore_updown_counter #(
   parameter int unsigned WIDTH   = 3,
   parameter int unsigned MODULUS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             at_max,
   output logic             at_zero,
   output logic             wrap,
   output logic             load_err
);

   generate
      if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 ||
          64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_params
         $error("moore_updown_counter: need WIDTH in 1..31 and 2 <= MODULUS <= 2**WIDTH");
      end
   endgenerate

   // MODULUS itself may need WIDTH+1 bits when it equals 2**WIDTH.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] state_d,    state_q;
   logic             wrap_d,     wrap_q;
   logic             load_err_d, load_err_q;

   always_comb begin
      state_d    = state_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (load) begin
         if ({1'b0, load_val} < MOD_EXT) begin
            state_d = load_val;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (en) begin
         if ({1'b0, state_q} >= MOD_EXT) begin
            state_d = '0;
         end else if (mode == DIR_UP) begin
            if (state_q == MAX_VAL) begin
               state_d = '0;
               wrap_d  = 1'b1;
            end else begin
               state_d = state_q + 1'b1;
            end
         end else begin
            if (state_q == '0) begin
               state_d = MAX_VAL;
               wrap_d  = 1'b1;
            end else begin
               state_d = state_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign at_max   = (state_q == MAX_VAL);
   assign at_zero  = (state_q == '0);
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

`ifdef MOORE_COUNTER_GRAY_OUT_EN
   gray_out_reg #(
      .WIDTH(WIDTH)
   ) u_gray_out_reg (
      .clk  (clk),
      .rst  (rst),
      .bin  (state_q),
      .gray (out)
   );
`else
   assign out = state_q;
`endif

endmodule

// File: tb/tb_moore_updown_counter.sv
// Directed self-checking bench: a MODULUS=8 and a MODULUS=6 instance share stimulus.
module tb_moore_updown_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       mode = 1'b1;
   logic       load = 1'b0;
   logic [2:0] load_val = '0;

   logic [2:0] out8, out6;
   logic       at_max8, at_zero8, wrap8, lerr8;
   logic       at_max6, at_zero6, wrap6, lerr6;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   moore_updown_counter #(.WIDTH(3), .MODULUS(8)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .out(out8), .at_max(at_max8), .at_zero(at_zero8), .wrap(wrap8), .load_err(lerr8)
   );

   moore_updown_counter #(.WIDTH(3), .MODULUS(6)) u_dut6 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .out(out6), .at_max(at_max6), .at_zero(at_zero6), .wrap(wrap6), .load_err(lerr6)
   );

   // Expected out given the state after this edge and the state before it.
   function automatic logic [2:0] exp_out(input logic [2:0] cur, input logic [2:0] prev);
`ifdef MOORE_COUNTER_GRAY_OUT_EN
      return prev ^ (prev >> 1);
`else
      return cur;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; load_val = 3'd5; en = 1'b1; mode = 1'b1;
      step();
      step();
      n_checks++; if (out8 !== 3'd0) begin n_errors++; $display("FAIL reset_out got %0d exp 0", out8); end
      n_checks++; if (at_zero8 !== 1'b1) begin n_errors++; $display("FAIL reset_at_zero got %b exp 1", at_zero8); end
      n_checks++; if (at_max8 !== 1'b0) begin n_errors++; $display("FAIL reset_at_max got %b exp 0", at_max8); end
      n_checks++; if (wrap8 !== 1'b0) begin n_errors++; $display("FAIL reset_wrap got %b exp 0", wrap8); end
      n_checks++; if (lerr8 !== 1'b0) begin n_errors++; $display("FAIL reset_load_err got %b exp 0", lerr8); end
   endtask

   task automatic test_up_wrap();
      logic [2:0] seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      logic       wr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0] prev = 3'd0;
      rst = 1'b0; load = 1'b0; en = 1'b1; mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++; if (out8 !== exp_out(seq[i], prev)) begin n_errors++; $display("FAIL up_out[%0d] got %0d exp %0d", i, out8, exp_out(seq[i], prev)); end
         n_checks++; if (wrap8 !== wr[i]) begin n_errors++; $display("FAIL up_wrap[%0d] got %b exp %b", i, wrap8, wr[i]); end
         n_checks++; if (at_max8 !== (seq[i] == 3'd7)) begin n_errors++; $display("FAIL up_at_max[%0d] got %b exp %b", i, at_max8, seq[i] == 3'd7); end
         n_checks++; if (at_zero8 !== (seq[i] == 3'd0)) begin n_errors++; $display("FAIL up_at_zero[%0d] got %b exp %b", i, at_zero8, seq[i] == 3'd0); end
         prev = seq[i];
      end
   endtask

   task automatic test_down_wrap();
      logic [2:0] seq [6] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      logic       wr  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] prev = 3'd0;
      rst = 1'b1; load = 1'b0; en = 1'b0;
      step();
      step();
      rst = 1'b0; en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++; if (out6 !== exp_out(seq[i], prev)) begin n_errors++; $display("FAIL down_out[%0d] got %0d exp %0d", i, out6, exp_out(seq[i], prev)); end
         n_checks++; if (wrap6 !== wr[i]) begin n_errors++; $display("FAIL down_wrap[%0d] got %b exp %b", i, wrap6, wr[i]); end
         n_checks++; if (at_max6 !== (seq[i] == 3'd5)) begin n_errors++; $display("FAIL down_at_max[%0d] got %b exp %b", i, at_max6, seq[i] == 3'd5); end
         prev = seq[i];
      end
   endtask

   task automatic test_load();
      // u_dut6 sits at 0 here
      load = 1'b1; load_val = 3'd4; en = 1'b0;
      step();
      n_checks++; if (out6 !== exp_out(3'd4, 3'd0)) begin n_errors++; $display("FAIL load4_out got %0d exp %0d", out6, exp_out(3'd4, 3'd0)); end
      n_checks++; if (lerr6 !== 1'b0) begin n_errors++; $display("FAIL load4_err got %b exp 0", lerr6); end
      load_val = 3'd7;
      step();
      n_checks++; if (out6 !== exp_out(3'd4, 3'd4)) begin n_errors++; $display("FAIL load7_out got %0d exp %0d", out6, exp_out(3'd4, 3'd4)); end
      n_checks++; if (lerr6 !== 1'b1) begin n_errors++; $display("FAIL load7_err got %b exp 1", lerr6); end
      n_checks++; if (lerr8 !== 1'b0) begin n_errors++; $display("FAIL load7_err_pow2 got %b exp 0", lerr8); end
      n_checks++; if (at_max8 !== 1'b1) begin n_errors++; $display("FAIL load7_at_max_pow2 got %b exp 1", at_max8); end
      load_val = 3'd6;
      step();
      n_checks++; if (lerr6 !== 1'b1) begin n_errors++; $display("FAIL load6_err got %b exp 1", lerr6); end
      n_checks++; if (at_max6 !== 1'b0) begin n_errors++; $display("FAIL load6_hold got %b exp 0", at_max6); end
      load = 1'b0;
      step();
      n_checks++; if (lerr6 !== 1'b0) begin n_errors++; $display("FAIL load_err_pulse got %b exp 0", lerr6); end
      load = 1'b1; load_val = 3'd5;
      step();
      n_checks++; if (at_max6 !== 1'b1) begin n_errors++; $display("FAIL load5_at_max got %b exp 1", at_max6); end
      n_checks++; if (lerr6 !== 1'b0) begin n_errors++; $display("FAIL load5_err got %b exp 0", lerr6); end
   endtask

   task automatic test_priority();
      // u_dut6 at 5
      load = 1'b1; load_val = 3'd2; en = 1'b1; mode = 1'b1;
      step();
      n_checks++; if (out6 !== exp_out(3'd2, 3'd5)) begin n_errors++; $display("FAIL prio_load_out got %0d exp %0d", out6, exp_out(3'd2, 3'd5)); end
      n_checks++; if (wrap6 !== 1'b0) begin n_errors++; $display("FAIL prio_load_wrap got %b exp 0", wrap6); end
      rst = 1'b1; load_val = 3'd3;
      step();
      n_checks++; if (at_zero6 !== 1'b1) begin n_errors++; $display("FAIL prio_rst_zero got %b exp 1", at_zero6); end
      n_checks++; if (out6 !== exp_out(3'd0, 3'd2)) begin n_errors++; $display("FAIL prio_rst_out got %0d exp %0d", out6, exp_out(3'd0, 3'd2)); end
      rst = 1'b0; load = 1'b0;
      step();
      n_checks++; if (out6 !== exp_out(3'd1, 3'd0)) begin n_errors++; $display("FAIL prio_restart_out got %0d exp %0d", out6, exp_out(3'd1, 3'd0)); end
   endtask

   task automatic test_hold_flip();
      logic [2:0] seq  [6] = '{3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
      logic       mdir [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0] prev = 3'd1;
      en = 1'b0; load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (out6 !== exp_out(3'd1, 3'd1)) begin n_errors++; $display("FAIL hold_out[%0d] got %0d exp %0d", i, out6, exp_out(3'd1, 3'd1)); end
         n_checks++; if (wrap6 !== 1'b0) begin n_errors++; $display("FAIL hold_wrap[%0d] got %b exp 0", i, wrap6); end
      end
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         mode = mdir[i];
         step();
         n_checks++; if (out6 !== exp_out(seq[i], prev)) begin n_errors++; $display("FAIL flip_out[%0d] got %0d exp %0d", i, out6, exp_out(seq[i], prev)); end
         prev = seq[i];
      end
      en = 1'b0;
   endtask

`ifdef MOORE_COUNTER_GRAY_OUT_EN
   task automatic test_gray();
      logic [2:0] g [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      logic [2:0] last;
      rst = 1'b1; load = 1'b0; en = 1'b0;
      step();
      step();
      rst = 1'b0; en = 1'b1; mode = 1'b1;
      last = out8;
      for (int i = 0; i < 9; i++) begin
         step();
         n_checks++; if (out8 !== g[i]) begin n_errors++; $display("FAIL gray_out[%0d] got %b exp %b", i, out8, g[i]); end
         n_checks++; if (at_max8 !== (i == 6)) begin n_errors++; $display("FAIL gray_at_max[%0d] got %b exp %b", i, at_max8, i == 6); end
         if (i > 0) begin
            n_checks++; if ($countones(out8 ^ last) !== 1) begin n_errors++; $display("FAIL gray_adjacent[%0d] got %b prev %b exp one bit change", i, out8, last); end
         end
         last = out8;
      end
      en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load();
      test_priority();
      test_hold_flip();
`ifdef MOORE_COUNTER_GRAY_OUT_EN
      test_gray();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
